// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the ALU execute/memory pipeline: default widths,
// the buffered entry record layout and the 2-entry buffer state encoding.
package alu_pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;

  // Field order here is the packing order used for every flattened entry.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic                  ofl;
    logic                  z;
    logic [REG_W_DEF-1:0]  wr_reg;
    logic                  wr_en;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_e;

  function automatic int entry_w(input int data_w, input int reg_w);
    return data_w + reg_w + 3;
  endfunction

endpackage

// File: rtl/ex_mem_entry.sv
// Single buffered pipeline entry: load-enabled register with synchronous clear
// and asynchronous active-low reset.
module ex_mem_entry #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Entry storage; clear wins over load so a discarded slot always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/ex_mem_buf.sv
// Two-entry in-order skid buffer between the ALU execute stage and the memory
// stage; handshakes are decoded from registered state only.
module ex_mem_buf
  import alu_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_ofl,
  input  logic              in_z,
  input  logic [REG_W-1:0]  in_wr_reg,
  input  logic              in_wr_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_ofl,
  output logic              out_z,
  output logic [REG_W-1:0]  out_wr_reg,
  output logic              out_wr_en,
  output logic [1:0]        count,
  output logic              ofl_seen
);

  localparam int EW = entry_w(DATA_W, REG_W);

  buf_state_e      state_r;
  buf_state_e      state_nxt_s;
  logic [EW-1:0]   in_ent_s;
  logic [EW-1:0]   head_q_s;
  logic [EW-1:0]   tail_q_s;
  logic [EW-1:0]   head_d_s;
  logic            head_ld_s;
  logic            head_clr_s;
  logic            tail_ld_s;
  logic            tail_clr_s;
  logic            push_s;
  logic            pop_s;
  logic            ofl_set_s;
  logic            ofl_seen_r;

  assign in_ent_s  = {in_result, in_ofl, in_z, in_wr_reg, in_wr_en};
  assign in_ready  = (state_r != FULL);
  assign out_valid = (state_r != EMPTY);
  assign count     = state_r;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // The head register drives out_* directly; it is cleared whenever the buffer
  // empties, so the payload reads zero with no output gating.
  assign out_result = head_q_s[EW-1 -: DATA_W];
  assign out_ofl    = head_q_s[REG_W+2];
  assign out_z      = head_q_s[REG_W+1];
  assign out_wr_reg = head_q_s[REG_W:1];
  assign out_wr_en  = head_q_s[0];

  assign ofl_set_s = pop_s & ~flush & out_ofl;
  assign ofl_seen  = ofl_seen_r;

  // Next-state and entry load/clear control; flush overrides every handshake.
  always_comb begin
    state_nxt_s = state_r;
    head_d_s    = in_ent_s;
    head_ld_s   = 1'b0;
    head_clr_s  = 1'b0;
    tail_ld_s   = 1'b0;
    tail_clr_s  = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
      head_clr_s  = 1'b1;
      tail_clr_s  = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            head_ld_s   = 1'b1;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_ld_s   = 1'b1;
            state_nxt_s = ONE;
          end else if (push_s) begin
            tail_ld_s   = 1'b1;
            state_nxt_s = FULL;
          end else if (pop_s) begin
            head_clr_s  = 1'b1;
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_d_s    = tail_q_s;
            head_ld_s   = 1'b1;
            tail_clr_s  = 1'b1;
            state_nxt_s = ONE;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          head_clr_s  = 1'b1;
          tail_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky overflow flag: only a real (non-flushed) pop of an ofl entry sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofl_seen_r <= 1'b0;
    end else if (ofl_set_s) begin
      ofl_seen_r <= 1'b1;
    end else begin
      ofl_seen_r <= ofl_seen_r;
    end
  end

  ex_mem_entry #(.W(EW)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (head_ld_s),
    .clr   (head_clr_s),
    .d     (head_d_s),
    .q     (head_q_s)
  );

  ex_mem_entry #(.W(EW)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tail_ld_s),
    .clr   (tail_clr_s),
    .d     (in_ent_s),
    .q     (tail_q_s)
  );

endmodule

// File: tb/tb_ex_mem_buf.sv
// Directed table-driven bench for ex_mem_buf plus hand-written sequences for
// asynchronous reset and flush/ofl_seen interaction.
module tb_ex_mem_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_ofl;
  logic        in_z;
  logic [2:0]  in_wr_reg;
  logic        in_wr_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_ofl;
  logic        out_z;
  logic [2:0]  out_wr_reg;
  logic        out_wr_en;
  logic [1:0]  count;
  logic        ofl_seen;

  int n_checks = 0;
  int n_pass   = 0;

  ex_mem_buf #(.DATA_W(16), .REG_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_ofl     (in_ofl),
    .in_z       (in_z),
    .in_wr_reg  (in_wr_reg),
    .in_wr_en   (in_wr_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ofl    (out_ofl),
    .out_z      (out_z),
    .out_wr_reg (out_wr_reg),
    .out_wr_en  (out_wr_en),
    .count      (count),
    .ofl_seen   (ofl_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] res;
    logic        ofl;
    logic        z;
    logic [2:0]  wr;
    logic        we;
    logic        fl;
    logic        ordy;
    logic [1:0]  e_cnt;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_res;
    logic        e_ofl;
    logic        e_z;
    logic [2:0]  e_wr;
    logic        e_we;
    logic        e_os;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic iv, input logic [15:0] res, input logic ofl, input logic z,
    input logic [2:0] wr, input logic we, input logic fl, input logic ordy,
    input logic [1:0] e_cnt, input logic e_ir, input logic e_ov,
    input logic [15:0] e_res, input logic e_ofl, input logic e_z,
    input logic [2:0] e_wr, input logic e_we, input logic e_os);
    vec_t v;
    v.iv = iv; v.res = res; v.ofl = ofl; v.z = z; v.wr = wr; v.we = we;
    v.fl = fl; v.ordy = ordy; v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_res = e_res; v.e_ofl = e_ofl; v.e_z = e_z; v.e_wr = e_wr;
    v.e_we = e_we; v.e_os = e_os;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] res, input logic ofl,
                       input logic z, input logic [2:0] wr, input logic we,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    in_result = res;
    in_ofl    = ofl;
    in_z      = z;
    in_wr_reg = wr;
    in_wr_en  = we;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int idx);
    check({tag, "_count"}, idx, 32'(count), 32'd0);
    check({tag, "_in_ready"}, idx, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, idx, 32'(out_valid), 32'd0);
    check({tag, "_out_payload"}, idx,
          32'({out_result, out_ofl, out_z, out_wr_reg, out_wr_en}), 32'd0);
  endtask

  initial begin
    // Rows: inputs for one clock edge, then expected outputs after that edge.
    //            iv   res       ofl  z    wr    we   fl   ordy  cnt  ir   ov   res       ofl  z    wr    we   os
    vecs[0]  = mk(1'b1,16'h1234,1'b0,1'b0,3'd3,1'b1,1'b0,1'b1, 2'd1,1'b1,1'b1,16'h1234,1'b0,1'b0,3'd3,1'b1,1'b0);
    vecs[1]  = mk(1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b0,1'b1, 2'd0,1'b1,1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b0);
    vecs[2]  = mk(1'b1,16'hAAAA,1'b0,1'b1,3'd5,1'b1,1'b0,1'b0, 2'd1,1'b1,1'b1,16'hAAAA,1'b0,1'b1,3'd5,1'b1,1'b0);
    vecs[3]  = mk(1'b1,16'h5555,1'b0,1'b0,3'd6,1'b0,1'b0,1'b0, 2'd2,1'b0,1'b1,16'hAAAA,1'b0,1'b1,3'd5,1'b1,1'b0);
    vecs[4]  = mk(1'b1,16'h7777,1'b1,1'b1,3'd7,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b1,16'hAAAA,1'b0,1'b1,3'd5,1'b1,1'b0);
    vecs[5]  = mk(1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b0,1'b1, 2'd1,1'b1,1'b1,16'h5555,1'b0,1'b0,3'd6,1'b0,1'b0);
    vecs[6]  = mk(1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b0,1'b1, 2'd0,1'b1,1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b0);
    vecs[7]  = mk(1'b1,16'h0001,1'b0,1'b0,3'd1,1'b1,1'b0,1'b0, 2'd1,1'b1,1'b1,16'h0001,1'b0,1'b0,3'd1,1'b1,1'b0);
    vecs[8]  = mk(1'b1,16'h0002,1'b0,1'b0,3'd2,1'b1,1'b0,1'b1, 2'd1,1'b1,1'b1,16'h0002,1'b0,1'b0,3'd2,1'b1,1'b0);
    vecs[9]  = mk(1'b1,16'h0003,1'b0,1'b0,3'd4,1'b1,1'b0,1'b0, 2'd2,1'b0,1'b1,16'h0002,1'b0,1'b0,3'd2,1'b1,1'b0);
    vecs[10] = mk(1'b1,16'h9999,1'b0,1'b0,3'd7,1'b1,1'b1,1'b1, 2'd0,1'b1,1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b0);
    vecs[11] = mk(1'b1,16'h8000,1'b1,1'b0,3'd2,1'b1,1'b0,1'b0, 2'd1,1'b1,1'b1,16'h8000,1'b1,1'b0,3'd2,1'b1,1'b0);
    vecs[12] = mk(1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b0,1'b1, 2'd0,1'b1,1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b1);
    vecs[13] = mk(1'b1,16'h4444,1'b0,1'b1,3'd3,1'b0,1'b0,1'b0, 2'd1,1'b1,1'b1,16'h4444,1'b0,1'b1,3'd3,1'b0,1'b1);
    vecs[14] = mk(1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b1,1'b0, 2'd0,1'b1,1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b1);

    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_idle("reset", 0);
    check("reset_ofl_seen", 0, 32'(ofl_seen), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].iv, vecs[i].res, vecs[i].ofl, vecs[i].z, vecs[i].wr,
            vecs[i].we, vecs[i].fl, vecs[i].ordy);
      step();
      check("count", i, 32'(count), 32'(vecs[i].e_cnt));
      check("in_ready", i, 32'(in_ready), 32'(vecs[i].e_ir));
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
      check("out_result", i, 32'(out_result), 32'(vecs[i].e_res));
      check("out_ofl", i, 32'(out_ofl), 32'(vecs[i].e_ofl));
      check("out_z", i, 32'(out_z), 32'(vecs[i].e_z));
      check("out_wr_reg", i, 32'(out_wr_reg), 32'(vecs[i].e_wr));
      check("out_wr_en", i, 32'(out_wr_en), 32'(vecs[i].e_we));
      check("ofl_seen", i, 32'(ofl_seen), 32'(vecs[i].e_os));
    end

    // Asynchronous reset while FULL with ofl_seen already set.
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'hCAFE, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    step();
    check("pre_rst_count", 100, 32'(count), 32'd2);
    check("pre_rst_ofl_seen", 100, 32'(ofl_seen), 32'd1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst", 101);
    check("async_rst_ofl_seen", 101, 32'(ofl_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First push after reset must behave as from EMPTY.
    drive(1'b1, 16'h0F0F, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    step();
    check("post_rst_count", 102, 32'(count), 32'd1);
    check("post_rst_result", 102, 32'(out_result), 32'h0F0F);
    check("post_rst_wr_reg", 102, 32'(out_wr_reg), 32'd4);

    // A pop coinciding with flush must not set ofl_seen.
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 16'h1111, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
    step();
    check("ofl_head_ofl", 103, 32'(out_ofl), 32'd1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    step();
    check_idle("flush_pop", 104);
    check("flush_pop_ofl_seen", 104, 32'(ofl_seen), 32'd0);

    // A genuine pop of an ofl entry sets it.
    drive(1'b1, 16'h2222, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1);
    step();
    check("ofl_push_seen", 105, 32'(ofl_seen), 32'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    check("ofl_pop_seen", 106, 32'(ofl_seen), 32'd1);
    check("ofl_pop_count", 106, 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_buf.md
EX_MEM_BUF -- requirements
Module: ex_mem_buf

Interface
REQ-001 Parameter DATA_W, default 16, ALU result width.
REQ-002 Parameter REG_W, default 3, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  execute stage presents a result this cycle.
REQ-006 in_ready  output  1  buffer can accept a result this cycle.
REQ-007 in_result  input  DATA_W  ALU Out.
REQ-008 in_ofl  input  1  ALU Ofl.
REQ-009 in_z  input  1  ALU Z.
REQ-010 in_wr_reg  input  REG_W  destination register index.
REQ-011 in_wr_en  input  1  result is written back.
REQ-012 flush  input  1  synchronous discard of all buffered and incoming results.
REQ-013 out_valid  output  1  head entry available to memory stage.
REQ-014 out_ready  input  1  memory stage consumes head this cycle.
REQ-015 out_result, out_ofl, out_z, out_wr_reg, out_wr_en  output  DATA_W/1/1/REG_W/1  head entry payload.
REQ-016 count  output  2  current occupancy, 0..2.
REQ-017 ofl_seen  output  1  sticky: some popped entry carried ofl=1.

Function
REQ-018 Block SHALL be a 2-entry in-order buffer between ALU execute and memory stage, states EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-019 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 in_ready SHALL equal (count != 2), derived from registered state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (count != 0), derived from registered state only.
REQ-022 Latency: result pushed in cycle N SHALL appear on out_* in cycle N+1 when the buffer was EMPTY or the sole entry popped in cycle N.
REQ-023 Transitions: EMPTY→ONE on push; ONE→FULL on push without pop; ONE→EMPTY on pop without push; ONE→ONE on push with pop, head replaced by new entry; FULL→ONE on pop; no push possible in FULL.
REQ-024 Order SHALL be preserved: entries leave in acceptance order; payload fields of one entry never mix with another's.
REQ-025 While count==0, out_result, out_ofl, out_z, out_wr_reg, out_wr_en SHALL all be 0.
REQ-026 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 flush SHALL have priority over push and pop: next state EMPTY, concurrent input discarded, concurrent pop treated as not occurring for ofl_seen.
REQ-028 ofl_seen SHALL set on the edge following a pop whose out_ofl=1 and hold until reset; flush does not clear it.
REQ-029 in_valid while in_ready=0 SHALL not alter state; upstream holds data.

Reset
REQ-030 rst_n low SHALL immediately force state EMPTY, count=0, in_ready=1, out_valid=0, all out_* payload 0, ofl_seen=0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard all entries; first push after deassertion behaves as from EMPTY.

Structure
REQ-032 Shared package alu_pipe_pkg SHALL hold DATA_W and REG_W defaults, the packed entry record (result, ofl, z, wr_reg, wr_en) and the 2-bit state encoding EMPTY=00, ONE=01, FULL=10.
REQ-033 One sub-module, ex_mem_entry, SHALL implement a single load-enabled, async-reset entry register, instantiated twice (head, tail).

Verification
REQ-034 Reset then push result 0x1234, wr_reg 3, wr_en 1, out_ready 1 -> next cycle out_valid 1, out_result 0x1234, out_wr_reg 3; following cycle count 0.
REQ-035 out_ready 0, push 0xAAAA then 0x5555 -> count 2, in_ready 0, out_result 0xAAAA stable; third in_valid ignored; raise out_ready -> 0xAAAA then 0x5555 in order.
REQ-036 count 1 holding 0x0001, simultaneous push 0x0002 and pop -> count stays 1, out_result 0x0002 next cycle.
REQ-037 FULL, assert flush with in_valid 1 -> next cycle count 0, out_valid 0, out_result 0, in_ready 1.
REQ-038 Push entry with in_ofl 1, pop it -> ofl_seen 1 next cycle, still 1 after flush; rst_n low mid-stream -> ofl_seen 0, count 0 without clock edge.
